// File: rtl/console_renderer_if.sv
// Memory-side bus of the console renderer: character RAM and font ROM ports.
// Both memories are synchronous; data follows the address by one clock.
interface console_renderer_if #(
    parameter int CA_W = 12,
    parameter int FA_W = 12,
    parameter int FW   = 8
);
    logic [CA_W-1:0] char_addr;
    logic [15:0]     char_data;
    logic [FA_W-1:0] font_addr;
    logic [FW-1:0]   font_data;

    modport master (
        output char_addr,
        output font_addr,
        input  char_data,
        input  font_data
    );

    modport slave (
        input  char_addr,
        input  font_addr,
        output char_data,
        output font_data
    );
endinterface

// File: rtl/console_renderer.sv
// Text-mode pixel pipeline: coordinate -> cell fetch -> font fetch -> RGB.
// Fixed 5-clock latency with colour attributes, blink, cursor and scroll.
module console_renderer #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int CHAR_W_LOG2  = 3,
    parameter int CHAR_H_LOG2  = 4,
    parameter int COLOR_DEPTH  = 1,
    parameter int CURSOR_LINES = 2,
    parameter int BLINK_FRAMES = 16,
    parameter bit SYNC_IDLE    = 1'b1,
    parameter int CA_W         = $clog2(COLS * ROWS),
    parameter int FA_W         = 8 + CHAR_H_LOG2,
    parameter int CW           = $clog2(COLS),
    parameter int RW           = $clog2(ROWS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [9:0]             x,
    input  logic [9:0]             y,
    input  logic                   de,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic [RW-1:0]          scroll_row,
    input  logic                   cursor_en,
    input  logic [CW-1:0]          cursor_col,
    input  logic [RW-1:0]          cursor_row,
    console_renderer_if.master     mem,
    output logic [COLOR_DEPTH-1:0] r,
    output logic [COLOR_DEPTH-1:0] g,
    output logic [COLOR_DEPTH-1:0] b,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic                   de_out
);
    localparam int CH = 1 << CHAR_H_LOG2;
    localparam int XW = 10 - CHAR_W_LOG2;
    localparam int YW = 10 - CHAR_H_LOG2;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef struct packed {
        logic                   vis;
        logic [CHAR_W_LOG2-1:0] sx;
        logic                   cur;
        logic                   ph;
    } meta_t;

    typedef struct packed {
        meta_t      m;
        logic [2:0] fg;
        logic [2:0] bg;
        logic       blink;
    } attr_t;

    logic [XW-1:0]          col;
    logic [YW-1:0]          row;
    logic [CHAR_H_LOG2-1:0] sy0;
    logic [RW-1:0]          scroll_eff;
    logic [RW:0]            row_sum;
    logic [RW-1:0]          phys_row;
    logic [CA_W-1:0]        addr_nxt;
    meta_t                  m0;

    meta_t                  s1, s2;
    logic [CHAR_H_LOG2-1:0] s1_sy, s2_sy;
    attr_t                  s3, s4;
    logic [4:0]             hs_d, vs_d, de_d;

    logic [BW-1:0]          blink_cnt;
    logic                   blink_ph;
    logic                   vs_rise;

    logic [2:0]             fg_e;
    logic [2:0]             pix;
    logic [CHAR_W_LOG2-1:0] bidx;
    logic                   unused_rsvd;

    assign unused_rsvd = mem.char_data[15];

    assign col = x[9:CHAR_W_LOG2];
    assign row = y[9:CHAR_H_LOG2];
    assign sy0 = y[CHAR_H_LOG2-1:0];

    // Scrolled physical row wraps back to the top of the buffer
    always_comb begin
        scroll_eff = (int'(scroll_row) >= ROWS) ? '0 : scroll_row;
        row_sum    = {1'b0, row[RW-1:0]} + {1'b0, scroll_eff};
        if (int'(row_sum) >= ROWS)
            row_sum = row_sum - (RW+1)'(ROWS);
        phys_row   = row_sum[RW-1:0];
        addr_nxt   = CA_W'(phys_row) * CA_W'(COLS) + CA_W'(col);
        m0.vis     = (int'(col) < COLS) && (int'(row) < ROWS);
        m0.sx      = x[CHAR_W_LOG2-1:0];
        m0.ph      = blink_ph;
        m0.cur     = cursor_en
                   && (col == XW'(cursor_col))
                   && (row == YW'(cursor_row))
                   && (int'(sy0) >= CH - CURSOR_LINES);
    end

    assign vs_rise = (vs_d[0] != SYNC_IDLE) && (vsync_in == SYNC_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b1;
        end else if (vs_rise) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Cursor wins over the glyph; blinking cells lose their foreground
    always_comb begin
        bidx = ~s4.m.sx;
        fg_e = (s4.blink && !s4.m.ph) ? s4.bg : s4.fg;
        pix  = s4.bg;
        if (s4.m.cur && s4.m.ph)
            pix = fg_e;
        else if (mem.font_data[bidx])
            pix = fg_e;
        if (!de_d[3] || !s4.m.vis)
            pix = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem.char_addr <= '0;
            mem.font_addr <= '0;
            s1            <= '0;
            s2            <= '0;
            s1_sy         <= '0;
            s2_sy         <= '0;
            s3            <= '0;
            s4            <= '0;
            hs_d          <= {5{SYNC_IDLE}};
            vs_d          <= {5{SYNC_IDLE}};
            de_d          <= '0;
            r             <= '0;
            g             <= '0;
            b             <= '0;
        end else begin
            if (m0.vis)
                mem.char_addr <= addr_nxt;
            s1            <= m0;
            s1_sy         <= sy0;
            s2            <= s1;
            s2_sy         <= s1_sy;
            s3.m          <= s2;
            s3.fg         <= mem.char_data[10:8];
            s3.blink      <= mem.char_data[11];
            s3.bg         <= mem.char_data[14:12];
            mem.font_addr <= {mem.char_data[7:0], s2_sy};
            s4            <= s3;
            hs_d          <= {hs_d[3:0], hsync_in};
            vs_d          <= {vs_d[3:0], vsync_in};
            de_d          <= {de_d[3:0], de};
            r             <= {COLOR_DEPTH{pix[2]}};
            g             <= {COLOR_DEPTH{pix[1]}};
            b             <= {COLOR_DEPTH{pix[0]}};
        end
    end

    assign hsync_out = hs_d[4];
    assign vsync_out = vs_d[4];
    assign de_out    = de_d[4];
endmodule

// File: tb/tb_console_renderer.sv
// Directed scoreboard bench for console_renderer (1-bit and 4-bit colour).
// Expectations are queued with their due cycle and checked on the falling edge.
module tb_console_renderer;
    localparam int K_CA = 0, K_FA = 1, K_RGB = 2, K_RGB4 = 3;
    localparam int K_DE = 4, K_HS = 5, K_VS = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] x = '0, y = '0;
    logic       de = 1'b0, hs_in = 1'b1, vs_in = 1'b1;
    logic [4:0] scroll = '0, crow = '0;
    logic [6:0] ccol = '0;
    logic       cen = 1'b0;

    logic       r, g, b, hs_out, vs_out, de_o;
    logic [3:0] r4, g4, b4;
    logic       hs4, vs4, de4;

    logic [15:0] cram [0:4095];
    logic [7:0]  fram [0:4095];

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] exp;
        string       tag;
    } sb_t;
    sb_t sb[$];

    console_renderer_if #(.CA_W(12), .FA_W(12), .FW(8)) mif ();
    console_renderer_if #(.CA_W(12), .FA_W(12), .FW(8)) mif4 ();

    console_renderer dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .de(de),
        .hsync_in(hs_in), .vsync_in(vs_in), .scroll_row(scroll),
        .cursor_en(cen), .cursor_col(ccol), .cursor_row(crow),
        .mem(mif), .r(r), .g(g), .b(b),
        .hsync_out(hs_out), .vsync_out(vs_out), .de_out(de_o)
    );

    console_renderer #(.COLOR_DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .x(x), .y(y), .de(de),
        .hsync_in(hs_in), .vsync_in(vs_in), .scroll_row(scroll),
        .cursor_en(cen), .cursor_col(ccol), .cursor_row(crow),
        .mem(mif4), .r(r4), .g(g4), .b(b4),
        .hsync_out(hs4), .vsync_out(vs4), .de_out(de4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        mif.char_data  <= cram[mif.char_addr];
        mif.font_data  <= fram[mif.font_addr];
        mif4.char_data <= cram[mif4.char_addr];
        mif4.font_data <= fram[mif4.font_addr];
    end

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic push(int dly, int kind, logic [31:0] exp, string tag);
        sb_t e;
        e.due  = cyc + dly;
        e.kind = kind;
        e.exp  = exp;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    function automatic logic [11:0] rep4(logic [2:0] c);
        return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
    endfunction

    task automatic step(int px, int py, bit pde, int er,
                        int eca = -1, int efa = -1,
                        bit hs = 1'b1, bit vs = 1'b1, string tag = "pix");
        x     = 10'(px);
        y     = 10'(py);
        de    = pde;
        hs_in = hs;
        vs_in = vs;
        push(5, K_RGB, 32'(er), {tag, "/rgb"});
        push(5, K_RGB4, 32'(rep4(3'(er))), {tag, "/rgb4"});
        push(5, K_DE, 32'(pde), {tag, "/de_out"});
        push(5, K_HS, 32'(hs), {tag, "/hsync_out"});
        push(5, K_VS, 32'(vs), {tag, "/vsync_out"});
        if (eca >= 0) push(1, K_CA, 32'(eca), {tag, "/char_addr"});
        if (efa >= 0) push(3, K_FA, 32'(efa), {tag, "/font_addr"});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                case (sb[i].kind)
                    K_CA:    chk(sb[i].tag, 32'(mif.char_addr), sb[i].exp);
                    K_FA:    chk(sb[i].tag, 32'(mif.font_addr), sb[i].exp);
                    K_RGB:   chk(sb[i].tag, 32'({r, g, b}), sb[i].exp);
                    K_RGB4:  chk(sb[i].tag, 32'({r4, g4, b4}), sb[i].exp);
                    K_DE:    chk(sb[i].tag, 32'(de_o), sb[i].exp);
                    K_HS:    chk(sb[i].tag, 32'(hs_out), sb[i].exp);
                    default: chk(sb[i].tag, 32'(vs_out), sb[i].exp);
                endcase
                sb.delete(i);
            end
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            cram[i] = '0;
            fram[i] = '0;
        end
        cram[0]    = 16'h0741;
        fram['h410] = 8'h80;
        cram[2320] = 16'h0142;
        fram['h420] = 8'hFF;
        cram[1]    = 16'h3543;
        fram['h430] = 8'h40;
        cram[4]    = 16'h1B44;
        fram['h440] = 8'hFF;
        cram[163]  = 16'h4200;

        repeat (3) @(posedge clk);
        #1;
        chk("rst/rgb", 32'({r, g, b}), 32'd0);
        chk("rst/hsync_out", 32'(hs_out), 32'd1);
        chk("rst/vsync_out", 32'(vs_out), 32'd1);
        chk("rst/de_out", 32'(de_o), 32'd0);
        chk("rst/char_addr", 32'(mif.char_addr), 32'd0);
        chk("rst/font_addr", 32'(mif.font_addr), 32'd0);
        rst = 1'b0;

        step(0, 0, 1'b1, 7, 0, 'h410, 1'b1, 1'b1, "glyph_on");
        step(1, 0, 1'b1, 0, 0, 'h410, 1'b1, 1'b1, "glyph_off");

        scroll = 5'd29;
        step(0, 0, 1'b1, 1, 2320, 'h420, 1'b1, 1'b1, "scroll29_r0");
        step(0, 16, 1'b1, 7, 0, 'h410, 1'b1, 1'b1, "scroll29_wrap");
        scroll = 5'd31;
        step(8, 0, 1'b1, 3, 1, 'h430, 1'b1, 1'b1, "scroll31_bg");
        step(9, 0, 1'b1, 5, 1, 'h430, 1'b1, 1'b1, "scroll31_fg5");

        step(640, 0, 1'b1, 0, 1, -1, 1'b1, 1'b1, "col_oob");
        step(100, 480, 1'b1, 0, 1, -1, 1'b1, 1'b1, "row_oob");
        step(0, 0, 1'b0, 0, -1, -1, 1'b1, 1'b1, "de_low");
        step(0, 0, 1'b0, 0, -1, -1, 1'b0, 1'b1, "hs_pulse");
        step(0, 0, 1'b0, 0, -1, -1, 1'b1, 1'b1, "hs_after");

        scroll = 5'd0;
        cen    = 1'b1;
        ccol   = 7'd3;
        crow   = 5'd2;
        step(25, 46, 1'b1, 2, 163, 'h00E, 1'b1, 1'b1, "cur_y46");
        step(31, 47, 1'b1, 2, 163, 'h00F, 1'b1, 1'b1, "cur_y47");
        step(24, 45, 1'b1, 4, 163, 'h00D, 1'b1, 1'b1, "cur_y45");
        step(32, 46, 1'b1, 0, 164, -1, 1'b1, 1'b1, "cur_col4");
        step(33, 0, 1'b1, 3, 4, 'h440, 1'b1, 1'b1, "blink_ph_on");

        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1'b0, 0, -1, -1, 1'b1, 1'b0, "vs_act");
            step(0, 0, 1'b0, 0, -1, -1, 1'b1, 1'b1, "vs_idle");
        end

        step(25, 46, 1'b1, 4, 163, -1, 1'b1, 1'b1, "cur_off_y46");
        step(31, 47, 1'b1, 4, 163, -1, 1'b1, 1'b1, "cur_off_y47");
        step(32, 0, 1'b1, 1, 4, 'h440, 1'b1, 1'b1, "blink_ph_off");
        step(35, 0, 1'b1, 1, 4, 'h440, 1'b1, 1'b1, "blink_ph_off2");

        cen = 1'b0;
        repeat (6) step(0, 0, 1'b1, 7, 0, 'h410, 1'b1, 1'b1, "pre_rst");
        chk("pre_rst/rgb_now", 32'({r, g, b}), 32'd7);
        sb.delete();
        #2 rst = 1'b1;
        #1;
        chk("midrst/rgb", 32'({r, g, b}), 32'd0);
        chk("midrst/hsync_out", 32'(hs_out), 32'd1);
        chk("midrst/vsync_out", 32'(vs_out), 32'd1);
        chk("midrst/de_out", 32'(de_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(4, K_RGB, 32'd0, "refill/rgb");
        push(4, K_DE, 32'd0, "refill/de_out");
        step(0, 0, 1'b1, 7, 0, 'h410, 1'b1, 1'b1, "post_rst");
        step(1, 0, 1'b1, 0, 0, 'h410, 1'b1, 1'b1, "post_rst_bg");

        repeat (7) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/console_renderer.md
Name: console_renderer

Overview:
Parametrised text-mode pixel pipeline, next generation of the console driver. Sits between the VGA sync generator and the character/font memories. Maps the incoming pixel coordinate to a character cell and fetches the cell's code and attribute, then fetches the font row and emits coloured RGB. Adds per-cell fg/bg colour, blink, hardware cursor, vertical scroll and sync realignment, all at a fixed latency.

Parameters:
COLS, 80, character columns
ROWS, 30, character rows
CHAR_W_LOG2, 3, log2 of cell width in pixels (font row width = 2^CHAR_W_LOG2)
CHAR_H_LOG2, 4, log2 of cell height in lines
COLOR_DEPTH, 1, bits per colour channel output
CURSOR_LINES, 2, bottom cell lines drawn as cursor
BLINK_FRAMES, 16, frames per blink half-period
SYNC_IDLE, 1, inactive level of hsync/vsync (reset value of delayed syncs)
CA_W, clog2(COLS*ROWS), char address width
FA_W, 8+CHAR_H_LOG2, font address width

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous active-high reset
x  in  10  pixel column from sync generator
y  in  10  pixel row
de  in  1  onScreen / display enable
hsync_in  in  1  raw hsync
vsync_in  in  1  raw vsync
scroll_row  in  clog2(ROWS)  first displayed text row
cursor_en  in  1  cursor enable
cursor_col  in  clog2(COLS)  cursor column
cursor_row  in  clog2(ROWS)  cursor row (logical, pre-scroll screen position)
char_addr  out  CA_W  char RAM read address
char_data  in  16  [7:0] code, [10:8] fg RGB, [11] blink, [14:12] bg RGB, [15] reserved
font_addr  out  FA_W  {code, sub_y} font ROM read address
font_data  in  2^CHAR_W_LOG2  font row, MSB = leftmost pixel
r, g, b  out  COLOR_DEPTH each  pixel colour
hsync_out, vsync_out  out  1  syncs aligned to r/g/b
de_out  out  1  de aligned to r/g/b

Behaviour:
- Both RAMs are synchronous: data valid one clk after address is registered.
- Pipeline, x/y/de sampled in cycle 0:
  - C0: col = x>>CHAR_W_LOG2, row = y>>CHAR_H_LOG2, sub_x, sub_y; phys_row = row+scroll_row, minus ROWS if >= ROWS; char_addr = phys_row*COLS+col, registered and valid in C1.
  - C2: char_data valid; font_addr registered, valid in C3.
  - C4: font_data valid; pixel composed and registered.
  - C5: r/g/b/de_out/hsync_out/vsync_out valid.
  - Fixed latency 5 clk. hsync/vsync/de pass through a 5-deep delay line.
- In-range: col < COLS and row < ROWS. Out-of-range pixel with de=1 -> rgb 0. No address is issued: char_addr holds its last value.
- de_out=0 -> rgb 0.
- scroll_row >= ROWS is treated as 0.
- Pixel colour:
  - bit = font_data[2^CHAR_W_LOG2-1-sub_x]; colour = bit ? fg : bg.
  - If the blink attribute is set and blink phase is off, fg := bg.
  - Cursor hit: cursor_en=1, col==cursor_col, row==cursor_row (screen row), sub_y >= 2^CHAR_H_LOG2-CURSOR_LINES, and blink phase on. On a hit the output is fg regardless of the font bit.
  - Each RGB bit is replicated to COLOR_DEPTH bits.
- Blink counter:
  - Increments on each vsync_in edge leaving the active level (i.e. transition to SYNC_IDLE).
  - At BLINK_FRAMES-1 it wraps to 0 and toggles the phase.
  - Reset: counter 0, phase on.
- Reset values: all pipeline registers, char_addr, font_addr, r/g/b and de_out are 0. hsync_out/vsync_out = SYNC_IDLE.
- Reset mid-frame: outputs go to reset values immediately. The pipeline refills, and valid output resumes 5 clk after the first post-reset sample.
- Inputs cursor_*/scroll_row are sampled in C0 and travel with the pixel. A change mid-line affects only pixels sampled after the change.

Test Plan:
- Defaults; char (0,0)=0x0741, font[0x41*16+0]=0x80. x=0,y=0,de=1 -> char_addr=0 at C1, font_addr=0x410 at C3, rgb=7 at C5. x=1 -> bg rgb=0.
- scroll_row=29, y=0 (row 0) -> phys_row 0? No: 29. char_addr=29*80=2320. y=16 (row 1) -> wrap to row 0, char_addr=0. scroll_row=31 -> treated 0.
- x=640 with de=1 -> rgb 0, char_addr unchanged; de=0 anywhere -> rgb 0, de_out low at 5-clk delay.
- Cursor at (3,2), cursor_en=1, blank font, fg=2: lines y=46,47 of cell -> rgb=2; y=45 -> bg. After 16 vsync edges the phase is off -> bg on all lines.
- Blink attribute set with phase off -> glyph pixels equal bg. Reset pulse mid-line -> r/g/b=0 and syncs=1 at once; valid output resumes 5 clk after rst falls.
- COLOR_DEPTH=4: fg=5 -> r=4'hF, g=0, b=4'hF. Sync delay measured at exactly 5 clk.
